// File: rtl/gpu_scb_pkg.sv
// gpu_scb_pkg: shared constants and the entry record for the per-warp scoreboard.
// Holds SCB_DEPTH (entries), SCB_ID_W (entry index width), REG_ID_W (register id width)
// and scb_entry_t. Optional feature macro used by scoreboard_warp: SCB_MEM_ORDER_EN.
package gpu_scb_pkg;
  localparam int SCB_DEPTH = 4;
  localparam int SCB_ID_W  = 2;
  localparam int REG_ID_W  = 5;
  typedef struct packed {
    logic                valid;
    logic                incomplete;
    logic                dst_valid;
    logic [REG_ID_W-1:0] dst;
  } scb_entry_t;
endpackage

// File: rtl/scoreboard_warp_if.sv
// scoreboard_warp_if: IBuffer/replay/writeback <-> scoreboard signal bundle.
// master drives instruction operands, grant, replay completion and writeback clear;
// slave (the scoreboard) returns full, dependent, allocation id and empty.
interface scoreboard_warp_if;
  logic [gpu_scb_pkg::REG_ID_W-1:0] src1_IB_Scb;
  logic [gpu_scb_pkg::REG_ID_W-1:0] src2_IB_Scb;
  logic [gpu_scb_pkg::REG_ID_W-1:0] dst_IB_Scb;
  logic                             src1_valid_IB_Scb;
  logic                             src2_valid_IB_Scb;
  logic                             dst_valid_IB_Scb;
  logic                             RP_grt_IB_Scb;
  logic                             replayable_IB_Scb;
  logic                             replay_complete;
  logic [gpu_scb_pkg::SCB_ID_W-1:0] replay_complete_ScbID;
  logic                             replay_SW_LWbar;
  logic                             clear_valid_WB_Scb;
  logic [gpu_scb_pkg::SCB_ID_W-1:0] clear_ScbID_WB_Scb;
  logic                             full_Scb_IB;
  logic                             dependent_Scb_IB;
  logic [gpu_scb_pkg::SCB_ID_W-1:0] ScbID_Scb_IB;
  logic                             empty_Scb;
  modport master (
    output src1_IB_Scb, src2_IB_Scb, dst_IB_Scb,
    output src1_valid_IB_Scb, src2_valid_IB_Scb, dst_valid_IB_Scb,
    output RP_grt_IB_Scb, replayable_IB_Scb,
    output replay_complete, replay_complete_ScbID, replay_SW_LWbar,
    output clear_valid_WB_Scb, clear_ScbID_WB_Scb,
    input  full_Scb_IB, dependent_Scb_IB, ScbID_Scb_IB, empty_Scb
  );
  modport slave (
    input  src1_IB_Scb, src2_IB_Scb, dst_IB_Scb,
    input  src1_valid_IB_Scb, src2_valid_IB_Scb, dst_valid_IB_Scb,
    input  RP_grt_IB_Scb, replayable_IB_Scb,
    input  replay_complete, replay_complete_ScbID, replay_SW_LWbar,
    input  clear_valid_WB_Scb, clear_ScbID_WB_Scb,
    output full_Scb_IB, dependent_Scb_IB, ScbID_Scb_IB, empty_Scb
  );
endinterface

// File: rtl/scb_free_encoder.sv
// scb_free_encoder: picks the lowest-index free scoreboard entry.
// Ports: valid (entry valid vector) in; free_id (lowest invalid index, 0 when full) out; full out.
module scb_free_encoder
  import gpu_scb_pkg::*;
(
  input  logic [SCB_DEPTH-1:0] valid,
  output logic [SCB_ID_W-1:0]  free_id,
  output logic                 full
);
  always_comb begin
    full    = &valid;
    free_id = !valid[0] ? 2'd0 :
              !valid[1] ? 2'd1 :
              !valid[2] ? 2'd2 :
              !valid[3] ? 2'd3 : 2'd0;
  end
endmodule

// File: rtl/scoreboard_warp.sv
// scoreboard_warp: 4-entry per-warp register scoreboard with replay tracking.
// Ports: clk (rising edge); rst (asynchronous, active-low); bus (scoreboard_warp_if.slave):
// operand ids/flags, grant, replayable, replay completion, writeback clear in;
// full, dependent, allocation id, empty out.
// Macro SCB_MEM_ORDER_EN: a replayable instruction is also held back while any
// valid entry is still incomplete (one outstanding memory op per warp).
module scoreboard_warp
  import gpu_scb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  scoreboard_warp_if.slave   bus
);
  scb_entry_t            entry_q [SCB_DEPTH];
  scb_entry_t            entry_d [SCB_DEPTH];
  logic [SCB_DEPTH-1:0]  valid_vec;
  logic [SCB_ID_W-1:0]   free_id;
  logic                  full;
  logic                  dependent;
  always_comb begin
    for (int i = 0; i < SCB_DEPTH; i++) valid_vec[i] = entry_q[i].valid;
  end
  scb_free_encoder u_free (
    .valid   (valid_vec),
    .free_id (free_id),
    .full    (full)
  );
  // Replay completion is applied before the writeback clear so a same-id writeback
  // always wins and invalidates; allocation only ever targets an invalid entry, so it
  // cannot collide with a clear or completion that did take effect.
  always_comb begin
    entry_d = entry_q;
    for (int i = 0; i < SCB_DEPTH; i++) begin
      if (bus.replay_complete && bus.replay_complete_ScbID == SCB_ID_W'(i) && entry_q[i].valid) begin
        if (bus.replay_SW_LWbar) entry_d[i].valid = 1'b0;
        else entry_d[i].incomplete = 1'b0;
      end
      if (bus.clear_valid_WB_Scb && bus.clear_ScbID_WB_Scb == SCB_ID_W'(i) && entry_q[i].valid)
        entry_d[i].valid = 1'b0;
      if (bus.RP_grt_IB_Scb && !full && free_id == SCB_ID_W'(i))
        entry_d[i] = '{valid: 1'b1, incomplete: bus.replayable_IB_Scb,
                       dst_valid: bus.dst_valid_IB_Scb, dst: bus.dst_IB_Scb};
    end
  end
  always_comb begin
    dependent = 1'b0;
    for (int i = 0; i < SCB_DEPTH; i++) begin
      if (entry_q[i].valid && entry_q[i].dst_valid &&
          ((bus.src1_valid_IB_Scb && bus.src1_IB_Scb == entry_q[i].dst) ||
           (bus.src2_valid_IB_Scb && bus.src2_IB_Scb == entry_q[i].dst) ||
           (bus.dst_valid_IB_Scb  && bus.dst_IB_Scb  == entry_q[i].dst)))
        dependent = 1'b1;
`ifdef SCB_MEM_ORDER_EN
      if (bus.replayable_IB_Scb && entry_q[i].valid && entry_q[i].incomplete)
        dependent = 1'b1;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) entry_q <= '{default: '0};
    else entry_q <= entry_d;
  end
  assign bus.full_Scb_IB      = full;
  assign bus.ScbID_Scb_IB     = free_id;
  assign bus.dependent_Scb_IB = dependent;
  assign bus.empty_Scb        = ~|valid_vec;
  // A grant while full is dropped by the allocation gate above; this flags the
  // upstream protocol slip in simulation without stopping the run.
  grt_while_full: assert property (@(posedge clk) disable iff (!rst) !(bus.RP_grt_IB_Scb && full))
    else $warning("RP_grt_IB_Scb asserted while scoreboard full; grant ignored");
endmodule

// File: tb/tb_scoreboard_warp.sv
// tb_scoreboard_warp: directed + randomized bench for scoreboard_warp against a behavioural model.
module tb_scoreboard_warp;
  import gpu_scb_pkg::*;
`ifdef SCB_MEM_ORDER_EN
  localparam bit MEM_ORD = 1'b1;
`else
  localparam bit MEM_ORD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  scoreboard_warp_if sif();
  scoreboard_warp dut (.clk(clk), .rst(rst), .bus(sif));
  int checks = 0;
  int errors = 0;
  bit         mv   [4];
  bit         minc [4];
  bit         mdv  [4];
  logic [4:0] mdst [4];
  bit         mf;
  logic [1:0] mfid;
  function automatic bit m_full();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(mv[i]);
    return n == 4;
  endfunction
  function automatic bit m_empty();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(mv[i]);
    return n == 0;
  endfunction
  function automatic logic [1:0] m_free();
    for (int i = 0; i < 4; i++) if (!mv[i]) return 2'(i);
    return 2'd0;
  endfunction
  function automatic bit m_dep();
    bit d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mv[i] && mdv[i]) begin
        if (sif.src1_valid_IB_Scb && sif.src1_IB_Scb == mdst[i]) d = 1'b1;
        if (sif.src2_valid_IB_Scb && sif.src2_IB_Scb == mdst[i]) d = 1'b1;
        if (sif.dst_valid_IB_Scb  && sif.dst_IB_Scb  == mdst[i]) d = 1'b1;
      end
      if (MEM_ORD && sif.replayable_IB_Scb && mv[i] && minc[i]) d = 1'b1;
    end
    return d;
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = 1'b0; minc[i] = 1'b0; mdv[i] = 1'b0; mdst[i] = 5'd0;
      end
    end else begin
      mf   = m_full();
      mfid = m_free();
      for (int i = 0; i < 4; i++) begin
        if (sif.replay_complete && sif.replay_complete_ScbID == 2'(i) && mv[i]) begin
          if (sif.replay_SW_LWbar) mv[i] = 1'b0;
          else minc[i] = 1'b0;
        end
        if (sif.clear_valid_WB_Scb && sif.clear_ScbID_WB_Scb == 2'(i)) mv[i] = 1'b0;
      end
      if (sif.RP_grt_IB_Scb && !mf) begin
        mv[mfid]   = 1'b1;
        minc[mfid] = sif.replayable_IB_Scb;
        mdv[mfid]  = sif.dst_valid_IB_Scb;
        mdst[mfid] = sif.dst_IB_Scb;
      end
    end
  end
  always @(negedge clk) begin
    chk("full_model",  8'(sif.full_Scb_IB),      8'(m_full()));
    chk("empty_model", 8'(sif.empty_Scb),        8'(m_empty()));
    chk("id_model",    8'(sif.ScbID_Scb_IB),     8'(m_free()));
    chk("dep_model",   8'(sif.dependent_Scb_IB), 8'(m_dep()));
  end
  task automatic idle();
    sif.src1_IB_Scb = '0; sif.src2_IB_Scb = '0; sif.dst_IB_Scb = '0;
    sif.src1_valid_IB_Scb = 1'b0; sif.src2_valid_IB_Scb = 1'b0; sif.dst_valid_IB_Scb = 1'b0;
    sif.RP_grt_IB_Scb = 1'b0; sif.replayable_IB_Scb = 1'b0;
    sif.replay_complete = 1'b0; sif.replay_complete_ScbID = '0; sif.replay_SW_LWbar = 1'b0;
    sif.clear_valid_WB_Scb = 1'b0; sif.clear_ScbID_WB_Scb = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_alloc(input logic [4:0] d, input bit dv, input bit repl);
    sif.RP_grt_IB_Scb = 1'b1; sif.dst_IB_Scb = d;
    sif.dst_valid_IB_Scb = dv; sif.replayable_IB_Scb = repl;
  endtask
  task automatic alloc(input logic [4:0] d, input bit dv, input bit repl);
    set_alloc(d, dv, repl);
    tick();
    idle();
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    chk("rst_full",  8'(sif.full_Scb_IB),      8'd0);
    chk("rst_dep",   8'(sif.dependent_Scb_IB), 8'd0);
    chk("rst_id",    8'(sif.ScbID_Scb_IB),     8'd0);
    chk("rst_empty", 8'(sif.empty_Scb),        8'd1);
    tick();
    rst = 1'b1;
  endtask
  initial begin
    idle();
    for (int i = 0; i < 4; i++) mdst[i] = 5'd0;
    do_reset();
    // single allocation and RAW detection
    alloc(5'd3, 1'b1, 1'b0);
    sif.src1_IB_Scb = 5'd3; sif.src1_valid_IB_Scb = 1'b1;
    @(negedge clk);
    chk("alloc1_id",    8'(sif.ScbID_Scb_IB),     8'd1);
    chk("alloc1_empty", 8'(sif.empty_Scb),        8'd0);
    chk("alloc1_dep",   8'(sif.dependent_Scb_IB), 8'd1);
    tick(); idle();
    // fill, then a grant while full must be dropped
    do_reset();
    for (int r = 1; r <= 4; r++) alloc(5'(r), 1'b1, 1'b0);
    @(negedge clk);
    chk("fill_full", 8'(sif.full_Scb_IB),  8'd1);
    chk("fill_id",   8'(sif.ScbID_Scb_IB), 8'd0);
    tick();
    alloc(5'd7, 1'b1, 1'b0);
    sif.src1_IB_Scb = 5'd7; sif.src1_valid_IB_Scb = 1'b1;
    @(negedge clk);
    chk("over_dep_r7", 8'(sif.dependent_Scb_IB), 8'd0);
    chk("over_full",   8'(sif.full_Scb_IB),      8'd1);
    tick();
    sif.src1_IB_Scb = 5'd4;
    @(negedge clk);
    chk("over_dep_r4", 8'(sif.dependent_Scb_IB), 8'd1);
    tick(); idle();
    // LW: incomplete ordering, completion, then writeback
    do_reset();
    alloc(5'd5, 1'b1, 1'b1);
    sif.replayable_IB_Scb = 1'b1; sif.src1_IB_Scb = 5'd6; sif.src1_valid_IB_Scb = 1'b1;
    sif.dst_IB_Scb = 5'd7; sif.dst_valid_IB_Scb = 1'b1;
    @(negedge clk);
    chk("memord_dep", 8'(sif.dependent_Scb_IB), 8'(MEM_ORD));
    tick();
    sif.replayable_IB_Scb = 1'b0;
    @(negedge clk);
    chk("memord_norepl_dep", 8'(sif.dependent_Scb_IB), 8'd0);
    tick(); idle();
    sif.replay_complete = 1'b1; sif.replay_complete_ScbID = 2'd0; sif.replay_SW_LWbar = 1'b0;
    tick(); idle();
    sif.replayable_IB_Scb = 1'b1;
    @(negedge clk);
    chk("lw_done_empty", 8'(sif.empty_Scb),        8'd0);
    chk("lw_done_dep",   8'(sif.dependent_Scb_IB), 8'd0);
    tick(); idle();
    sif.src1_IB_Scb = 5'd5; sif.src1_valid_IB_Scb = 1'b1;
    @(negedge clk);
    chk("lw_still_valid_dep", 8'(sif.dependent_Scb_IB), 8'd1);
    tick(); idle();
    sif.clear_valid_WB_Scb = 1'b1; sif.clear_ScbID_WB_Scb = 2'd0;
    tick(); idle();
    @(negedge clk);
    chk("lw_wb_empty", 8'(sif.empty_Scb), 8'd1);
    tick();
    // SW completion invalidates
    do_reset();
    alloc(5'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sw_alloc_empty", 8'(sif.empty_Scb), 8'd0);
    tick();
    sif.replay_complete = 1'b1; sif.replay_complete_ScbID = 2'd0; sif.replay_SW_LWbar = 1'b1;
    tick(); idle();
    @(negedge clk);
    chk("sw_done_empty", 8'(sif.empty_Scb), 8'd1);
    tick();
    // same-id LW completion and writeback clear together invalidate
    do_reset();
    alloc(5'd5, 1'b1, 1'b1);
    sif.replay_complete = 1'b1; sif.replay_complete_ScbID = 2'd0; sif.replay_SW_LWbar = 1'b0;
    sif.clear_valid_WB_Scb = 1'b1; sif.clear_ScbID_WB_Scb = 2'd0;
    tick(); idle();
    @(negedge clk);
    chk("both_empty", 8'(sif.empty_Scb), 8'd1);
    tick();
    // clear/completion on invalid entries ignored
    alloc(5'd8, 1'b1, 1'b0);
    sif.clear_valid_WB_Scb = 1'b1; sif.clear_ScbID_WB_Scb = 2'd2;
    sif.replay_complete = 1'b1; sif.replay_complete_ScbID = 2'd3; sif.replay_SW_LWbar = 1'b1;
    tick(); idle();
    @(negedge clk);
    chk("inv_clr_empty", 8'(sif.empty_Scb),    8'd0);
    chk("inv_clr_id",    8'(sif.ScbID_Scb_IB), 8'd1);
    tick();
    // allocation and writeback clear in the same cycle
    do_reset();
    alloc(5'd1, 1'b1, 1'b0);
    alloc(5'd2, 1'b1, 1'b0);
    alloc(5'd3, 1'b1, 1'b0);
    set_alloc(5'd9, 1'b1, 1'b0);
    sif.clear_valid_WB_Scb = 1'b1; sif.clear_ScbID_WB_Scb = 2'd1;
    tick(); idle();
    @(negedge clk);
    chk("swap_id",   8'(sif.ScbID_Scb_IB), 8'd1);
    chk("swap_full", 8'(sif.full_Scb_IB),  8'd0);
    tick();
    sif.src1_IB_Scb = 5'd9; sif.src1_valid_IB_Scb = 1'b1;
    @(negedge clk);
    chk("swap_dep_new", 8'(sif.dependent_Scb_IB), 8'd1);
    tick();
    sif.src1_IB_Scb = 5'd2;
    @(negedge clk);
    chk("swap_dep_freed", 8'(sif.dependent_Scb_IB), 8'd0);
    tick(); idle();
    // randomized traffic with occasional mid-operation reset
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) begin
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        sif.src1_IB_Scb = 5'($urandom_range(0, 7));
        sif.src2_IB_Scb = 5'($urandom_range(0, 7));
        sif.dst_IB_Scb  = 5'($urandom_range(0, 7));
        sif.src1_valid_IB_Scb = 1'($urandom_range(0, 1));
        sif.src2_valid_IB_Scb = 1'($urandom_range(0, 1));
        sif.dst_valid_IB_Scb  = 1'($urandom_range(0, 1));
        sif.replayable_IB_Scb = 1'($urandom_range(0, 1));
        sif.RP_grt_IB_Scb = !m_full() && ($urandom_range(0, 2) != 0);
        sif.replay_complete = ($urandom_range(0, 3) == 0);
        sif.replay_complete_ScbID = 2'($urandom_range(0, 3));
        sif.replay_SW_LWbar = 1'($urandom_range(0, 1));
        sif.clear_valid_WB_Scb = ($urandom_range(0, 3) == 0);
        sif.clear_ScbID_WB_Scb = 2'($urandom_range(0, 3));
        tick();
      end
    end
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
